// File: rtl/lsu.sv
// Load/store unit: one data-memory transaction per request over a valid/ack bus.
// Optional macro MISALIGN_TRAP_EN turns misaligned half/word accesses into errors.
module lsu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_we,
   input  logic [2:0]       req_funct3,
   input  logic [WIDTH-1:0] req_addr,
   input  logic [WIDTH-1:0] req_wdata,
   output logic             mem_req,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_addr,
   output logic [3:0]       mem_be,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic             mem_ack,
   input  logic [WIDTH-1:0] mem_rdata,
   output logic             resp_valid,
   output logic [WIDTH-1:0] resp_rdata,
   output logic             resp_err
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

   state_t           state_q, state_d;
   logic             req_ready_q, req_ready_d;
   logic             mem_req_q, mem_req_d;
   logic             mem_we_q, mem_we_d;
   logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [3:0]       mem_be_q, mem_be_d;
   logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic [2:0]       funct3_q, funct3_d;
   logic [1:0]       off_q, off_d;
   logic             resp_valid_q, resp_valid_d;
   logic [WIDTH-1:0] resp_rdata_q, resp_rdata_d;
   logic             resp_err_q, resp_err_d;

   logic             err_s;
   logic [1:0]       lane_s;
   logic [3:0]       be_s;
   logic [WIDTH-1:0] wdata_s;
   logic [WIDTH-1:0] shifted_s;
   logic [WIDTH-1:0] load_s;

   function automatic logic legal_f3(input logic we, input logic [2:0] f3);
      logic ok;
      case (f3)
         3'b000, 3'b001, 3'b010: ok = 1'b1;
         3'b100, 3'b101:         ok = !we;
         default:                ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Next-state, lane steering and load extension.
   always_comb begin
      state_d      = state_q;
      req_ready_d  = req_ready_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_be_d     = mem_be_q;
      mem_wdata_d  = mem_wdata_q;
      funct3_d     = funct3_q;
      off_d        = off_q;
      resp_valid_d = resp_valid_q;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;

      err_s = !legal_f3(req_we, req_funct3);
`ifdef MISALIGN_TRAP_EN
      if ((req_funct3[1:0] == 2'b01 && req_addr[0]) ||
          (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)) begin
         err_s = 1'b1;
      end else begin
         err_s = err_s;
      end
`endif

      // Word accesses ignore the low address bits entirely.
      case (req_funct3[1:0])
         2'b00: begin
            lane_s  = req_addr[1:0];
            be_s    = 4'b0001 << lane_s;
            wdata_s = req_wdata << {lane_s, 3'b000};
         end
         2'b01: begin
            lane_s  = req_addr[1:0];
            be_s    = 4'b0011 << lane_s;
            wdata_s = req_wdata << {lane_s, 3'b000};
         end
         default: begin
            lane_s  = 2'b00;
            be_s    = 4'hF;
            wdata_s = req_wdata;
         end
      endcase

      shifted_s = mem_rdata >> {off_q, 3'b000};
      case (funct3_q)
         3'b000:  load_s = {{24{shifted_s[7]}}, shifted_s[7:0]};
         3'b001:  load_s = {{16{shifted_s[15]}}, shifted_s[15:0]};
         3'b100:  load_s = {24'h000000, shifted_s[7:0]};
         3'b101:  load_s = {16'h0000, shifted_s[15:0]};
         default: load_s = shifted_s;
      endcase

      case (state_q)
         S_IDLE: begin
            if (req_valid && req_ready_q) begin
               req_ready_d = 1'b0;
               funct3_d    = req_funct3;
               off_d       = lane_s;
               if (err_s) begin
                  state_d      = S_RESP;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
                  resp_rdata_d = 32'h0000_0000;
               end else begin
                  state_d     = S_WAIT;
                  mem_req_d   = 1'b1;
                  mem_we_d    = req_we;
                  mem_addr_d  = {req_addr[WIDTH-1:2], 2'b00};
                  mem_be_d    = be_s;
                  mem_wdata_d = wdata_s;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WAIT: begin
            if (mem_ack) begin
               state_d      = S_RESP;
               mem_req_d    = 1'b0;
               resp_valid_d = 1'b1;
               resp_err_d   = 1'b0;
               resp_rdata_d = mem_we_q ? 32'h0000_0000 : load_s;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_RESP: begin
            state_d      = S_IDLE;
            resp_valid_d = 1'b0;
            req_ready_d  = 1'b1;
         end
         default: begin
            state_d      = S_IDLE;
            req_ready_d  = 1'b1;
            mem_req_d    = 1'b0;
            resp_valid_d = 1'b0;
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         req_ready_q  <= 1'b1;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= 32'h0000_0000;
         mem_be_q     <= 4'h0;
         mem_wdata_q  <= 32'h0000_0000;
         funct3_q     <= 3'b000;
         off_q        <= 2'b00;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 32'h0000_0000;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         req_ready_q  <= req_ready_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_be_q     <= mem_be_d;
         mem_wdata_q  <= mem_wdata_d;
         funct3_q     <= funct3_d;
         off_q        <= off_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
      end
   end

   assign req_ready  = req_ready_q;
   assign mem_req    = mem_req_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_be     = mem_be_q;
   assign mem_wdata  = mem_wdata_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: a request-level model predicts bus fields and
// responses; a negedge compare process checks them, plus literal spot checks.
module tb_lsu;
   logic        clk = 1'b0;
   logic        rst, req_valid, req_we, mem_ack;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata, mem_rdata;
   logic        req_ready, mem_req, mem_we, resp_valid, resp_err;
   logic [31:0] mem_addr, mem_wdata, resp_rdata;
   logic [3:0]  mem_be;

   int passed = 0;
   int total  = 0;

   logic        exp_err, exp_we;
   logic [31:0] exp_maddr, exp_wdata, exp_rdata;
   logic [3:0]  exp_be;
   logic        chk_en = 1'b0;
   logic [31:0] last_resp_rdata, last_maddr, last_wdata;
   logic [3:0]  last_be;
   logic        last_err, last_we;

   lsu #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
      .req_wdata(req_wdata), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .resp_valid(resp_valid),
      .resp_rdata(resp_rdata), .resp_err(resp_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Request-level model: what the bus and the response must look like.
   task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd);
      int off;
      logic [7:0] bytes [4];
      logic [7:0] b0, b1;
      logic legal;
      off = int'(addr[1:0]);
      for (int i = 0; i < 4; i++) bytes[i] = rd[8*i +: 8];
      legal = we ? (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)
                 : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      exp_err = !legal;
`ifdef MISALIGN_TRAP_EN
      if ((f3[1:0] == 2'd1 && addr[0]) || (f3[1:0] == 2'd2 && off != 0)) exp_err = 1'b1;
`endif
      exp_we    = we;
      exp_maddr = {addr[31:2], 2'b00};
      if (f3[1:0] == 2'd2) off = 0;
      case (f3[1:0])
         2'd0:    exp_be = 4'(1 << off);
         2'd1:    exp_be = 4'(3 << off);
         default: exp_be = 4'hF;
      endcase
      exp_wdata = (f3[1:0] == 2'd2) ? wd : (wd << (8*off));
      b0 = bytes[off];
      b1 = (off < 3) ? bytes[off+1] : 8'h00;
      case (f3)
         3'd0:    exp_rdata = {{24{b0[7]}}, b0};
         3'd1:    exp_rdata = {{16{b1[7]}}, b1, b0};
         3'd4:    exp_rdata = {24'h0, b0};
         3'd5:    exp_rdata = {16'h0, b1, b0};
         default: exp_rdata = rd;
      endcase
      if (we || exp_err) exp_rdata = 32'h0;
   endtask

   // Compare process: bus fields while requesting, data on every response.
   always @(negedge clk) begin
      if (chk_en) begin
         if (mem_req) begin
            chk("bus_noerr", {31'h0, exp_err}, 32'h0);
            chk("mem_addr", mem_addr, exp_maddr);
            chk("mem_be", {28'h0, mem_be}, {28'h0, exp_be});
            chk("mem_we", {31'h0, mem_we}, {31'h0, exp_we});
            if (exp_we) chk("mem_wdata", mem_wdata, exp_wdata);
            last_maddr = mem_addr; last_be = mem_be; last_wdata = mem_wdata; last_we = mem_we;
         end
         if (resp_valid) begin
            chk("resp_err", {31'h0, resp_err}, {31'h0, exp_err});
            chk("resp_rdata", resp_rdata, exp_rdata);
            last_resp_rdata = resp_rdata; last_err = resp_err;
         end
      end
   end

   task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input int dly, input logic [31:0] rd);
      model(we, f3, addr, wd, rd);
      chk("ready_before", {31'h0, req_ready}, 32'h1);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      @(posedge clk); #1;
      req_valid = 1'b0;
      if (exp_err) begin
         chk("err_nobus", {31'h0, mem_req}, 32'h0);
         chk("err_lat", {31'h0, resp_valid}, 32'h1);
      end else begin
         chk("req_lat", {31'h0, mem_req}, 32'h1);
         for (int i = 0; i < dly; i++) begin
            @(posedge clk); #1;
            chk("wait_hold", {30'h0, mem_req, resp_valid}, 32'h2);
         end
         mem_ack = 1'b1; mem_rdata = rd;
         @(posedge clk); #1;
         mem_ack = 1'b0; mem_rdata = 32'h0;
         chk("resp_lat", {30'h0, mem_req, resp_valid}, 32'h1);
      end
      @(posedge clk); #1;
      chk("resp_pulse", {30'h0, resp_valid, req_ready}, 32'h1);
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
      req_addr = 32'h0; req_wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", {31'h0, req_ready}, 32'h1);
      chk("rst_ctl", {28'h0, mem_req, mem_we, resp_valid, resp_err}, 32'h0);
      chk("rst_addr", mem_addr, 32'h0);
      chk("rst_be", {28'h0, mem_be}, 32'h0);
      chk("rst_wdata", mem_wdata, 32'h0);
      chk("rst_rdata", resp_rdata, 32'h0);
      rst = 1'b0;
      chk_en = 1'b1;
      @(posedge clk); #1;

      txn(1'b0, 3'b010, 32'h100, 32'h0, 3, 32'hDEADBEEF);
      chk("lw_lit_addr", last_maddr, 32'h100);
      chk("lw_lit_be", {28'h0, last_be}, 32'hF);
      chk("lw_lit_data", last_resp_rdata, 32'hDEADBEEF);
      txn(1'b0, 3'b000, 32'h103, 32'h0, 0, 32'h80FF_FF00);
      chk("lb_lit_be", {28'h0, last_be}, 32'h8);
      chk("lb_lit_data", last_resp_rdata, 32'hFFFFFF80);
      txn(1'b0, 3'b100, 32'h103, 32'h0, 1, 32'h80FF_FF00);
      chk("lbu_lit_data", last_resp_rdata, 32'h00000080);
      txn(1'b1, 3'b001, 32'h202, 32'h0000_1234, 2, 32'h0);
      chk("sh_lit_be", {28'h0, last_be}, 32'hC);
      chk("sh_lit_wdata", last_wdata, 32'h1234_0000);
      chk("sh_lit_we", {31'h0, last_we}, 32'h1);
      txn(1'b0, 3'b011, 32'h100, 32'h0, 0, 32'h0);
      chk("bad_lit_err", {31'h0, last_err}, 32'h1);
      txn(1'b0, 3'b010, 32'h101, 32'h0, 0, 32'h1122_3344);
`ifndef MISALIGN_TRAP_EN
      chk("lw_mis_lit_addr", last_maddr, 32'h100);
`endif
      txn(1'b0, 3'b001, 32'h102, 32'h0, 0, 32'h8001_0000);
      chk("lh_lit_data", last_resp_rdata, 32'hFFFF8001);
      txn(1'b0, 3'b101, 32'h100, 32'h0, 0, 32'hAAAA_F00D);
      chk("lhu_lit_data", last_resp_rdata, 32'h0000F00D);
      txn(1'b1, 3'b000, 32'h201, 32'h0000_00AB, 0, 32'h0);
      chk("sb_lit_wdata", last_wdata, 32'h0000_AB00);
      txn(1'b1, 3'b010, 32'h300, 32'hCAFE_F00D, 1, 32'h0);
      txn(1'b1, 3'b100, 32'h300, 32'h1, 0, 32'h0);
      txn(1'b0, 3'b110, 32'h300, 32'h1, 0, 32'h0);
      txn(1'b0, 3'b001, 32'h103, 32'h0, 0, 32'hF0A5_0000);
      txn(1'b1, 3'b001, 32'h103, 32'h0000_5A5A, 0, 32'h0);

      // Stray ack while idle must not produce a response.
      mem_ack = 1'b1;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      chk("stray_ack", {30'h0, resp_valid, req_ready}, 32'h1);

      // Reset during WAIT, followed by a late ack.
      model(1'b0, 3'b010, 32'h400, 32'h0, 32'h0);
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h400;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("rstw_req", {31'h0, mem_req}, 32'h1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rstw_drop", {30'h0, mem_req, req_ready}, 32'h1);
      mem_ack = 1'b1;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      chk("rstw_late", {30'h0, resp_valid, req_ready}, 32'h1);
      @(posedge clk); #1;
      chk("rstw_quiet", {30'h0, resp_valid, mem_req}, 32'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end
endmodule
